// File: rtl/magnetron_power_ctrl_pkg.sv
// Shared state encodings and default sizing for the magnetron power controller.
package magnetron_power_ctrl_pkg;

  localparam int DEF_MAX_LEVEL   = 10;
  localparam int DEF_SLOT_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COOK   = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/magnetron_power_ctrl_duty.sv
// Time-proportional duty window: wrap counter over PERIOD cycles, on while below lvl*SLOT_CYCLES.
module mag_duty_gen
  import magnetron_power_ctrl_pkg::*;
#(
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int LVL_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [LVL_W-1:0] lvl,
  output logic             duty_on
);

  localparam int PERIOD = MAX_LEVEL * SLOT_CYCLES;
  localparam int CNT_W  = $clog2(PERIOD) + 1;

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] thr;

  // Counter holds whenever run is low, so a pause resumes mid-window.
  always_ff @(posedge clk) begin
    if (rst || clr)
      win_cnt <= '0;
    else if (run)
      win_cnt <= (win_cnt == CNT_W'(PERIOD - 1)) ? '0 : win_cnt + CNT_W'(1);
  end

  assign thr     = CNT_W'(lvl) * CNT_W'(SLOT_CYCLES);
  assign duty_on = (win_cnt < thr);

endmodule

// File: rtl/magnetron_power_ctrl.sv
// Magnetron gate FSM with selectable power level; MAG_PAUSE_EN enables the PAUSED state.
module magnetron_power_ctrl
  import magnetron_power_ctrl_pkg::*;
#(
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int LVL_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [LVL_W-1:0] power_level,
  output logic             mag_on,
  output logic             cooking,
  output logic             paused
);

`ifdef MAG_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  state_t           state, state_nx;
  logic [LVL_W-1:0] lvl_q, lvl_clamped;
  logic             start_ok;
  logic             duty_on;
  logic             run, clr;

  assign start_ok = !startn && door_closed && stopn && clearn && !timer_done;

  always_comb begin
    lvl_clamped = power_level;
    if (power_level > LVL_W'(MAX_LEVEL))
      lvl_clamped = LVL_W'(MAX_LEVEL);
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start_ok && (power_level != '0))
          state_nx = ST_COOK;
      end
      ST_COOK: begin
        if (!clearn)
          state_nx = ST_IDLE;
        else if (timer_done)
          state_nx = ST_IDLE;
        else if (!stopn || !door_closed)
          state_nx = PAUSE_EN ? ST_PAUSED : ST_IDLE;
      end
      ST_PAUSED: begin
        if (!clearn || timer_done)
          state_nx = ST_IDLE;
        else if (start_ok)
          state_nx = ST_COOK;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Level is latched only on a fresh start; resume keeps the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lvl_q <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == ST_IDLE)
        lvl_q <= '0;
      else if ((state == ST_IDLE) && (state_nx == ST_COOK))
        lvl_q <= lvl_clamped;
    end
  end

  assign run = (state == ST_COOK) && (state_nx == ST_COOK);
  assign clr = (state_nx == ST_IDLE);

  mag_duty_gen #(
    .MAX_LEVEL  (MAX_LEVEL),
    .SLOT_CYCLES(SLOT_CYCLES),
    .LVL_W      (LVL_W)
  ) u_duty (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .clr    (clr),
    .lvl    (lvl_q),
    .duty_on(duty_on)
  );

  assign cooking = (state == ST_COOK);
  assign mag_on  = cooking && duty_on;
  assign paused  = PAUSE_EN && (state == ST_PAUSED);

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Scoreboard bench: stimulus queues expected {mag_on,cooking,paused}; monitor checks each falling edge.
module tb_magnetron_power_ctrl;

  logic       clk = 1'b0;
  logic       rst, startn, stopn, clearn, door_closed, timer_done;
  logic [3:0] power_level;
  logic       mag_on, cooking, paused;

  int n_tests = 0;
  int n_fail  = 0;

  string      nq[$];
  logic [2:0] vq[$];

`ifdef MAG_PAUSE_EN
  localparam logic [2:0] PAUSE_EXP = 3'b001;
`else
  localparam logic [2:0] PAUSE_EXP = 3'b000;
`endif

  magnetron_power_ctrl #(
    .MAX_LEVEL  (10),
    .SLOT_CYCLES(4),
    .LVL_W      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .timer_done (timer_done),
    .power_level(power_level),
    .mag_on     (mag_on),
    .cooking    (cooking),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic s, input logic sp, input logic cl, input logic d,
                       input logic td, input logic [3:0] lv);
    startn = s; stopn = sp; clearn = cl; door_closed = d; timer_done = td; power_level = lv;
  endtask

  // Queue the outputs expected after the next rising edge, then advance.
  task automatic cyc(input string nm, input logic [2:0] e);
    nq.push_back(nm);
    vq.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (vq.size() > 0) begin
      string      nm;
      logic [2:0] e, a;
      nm = nq.pop_front();
      e  = vq.pop_front();
      a  = {mag_on, cooking, paused};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got mag/cook/pause=%b expected %b", nm, a, e);
      end
    end
  end

  initial begin
    logic e;
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
    cyc("reset", 3'b000);
    cyc("reset", 3'b000);
    rst = 1'b0;

    // level 3: 12 on, 28 off over the 40-cycle window
    for (int k = 0; k < 80; k++) begin
      startn = (k == 0) ? 1'b0 : 1'b1;
      cyc("lvl3_duty", {((k % 40) < 12), 1'b1, 1'b0});
    end
    stopn = 1'b0;
    cyc("stop_exit", PAUSE_EXP);
    stopn = 1'b1; clearn = 1'b0;
    cyc("clear_idle", 3'b000);
    clearn = 1'b1;

    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc("lvl0_ignored", 3'b000);
    cyc("lvl0_ignored", 3'b000);
    power_level = 4'd15;
    cyc("lvl15_start", 3'b110);
    startn = 1'b1;
    for (int k = 0; k < 45; k++) cyc("lvl15_full", 3'b110);
    clearn = 1'b0; timer_done = 1'b1;
    cyc("clear_and_done", 3'b000);
    clearn = 1'b1; timer_done = 1'b0;
    cyc("idle_hold", 3'b000);

    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
    cyc("hold_stop", 3'b000);
    cyc("hold_stop", 3'b000);
    stopn = 1'b1; clearn = 1'b0;
    cyc("hold_clear", 3'b000);
    cyc("hold_clear", 3'b000);
    clearn = 1'b1; timer_done = 1'b1;
    cyc("hold_done", 3'b000);
    cyc("hold_done", 3'b000);
    timer_done = 1'b0;
    for (int k = 0; k < 10; k++) cyc("level_restart", {(k < 8), 1'b1, 1'b0});
    startn = 1'b1; timer_done = 1'b1;
    cyc("done_exit", 3'b000);
    timer_done = 1'b0;
    cyc("idle_after_done", 3'b000);

    // door opens with win_cnt=5 visible
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
    for (int k = 0; k < 6; k++) begin
      startn = (k == 0) ? 1'b0 : 1'b1;
      cyc("pre_door", {(k < 8), 1'b1, 1'b0});
    end
    door_closed = 1'b0;
    cyc("door_open", PAUSE_EXP);
    cyc("door_open_hold", PAUSE_EXP);
    door_closed = 1'b1; power_level = 4'd7; startn = 1'b0;
    for (int j = 0; j < 36; j++) begin
      if (j == 1) startn = 1'b1;
`ifdef MAG_PAUSE_EN
      e = (((5 + j) % 40) < 8);
`else
      e = (j < 28);
`endif
      cyc("restart_window", {e, 1'b1, 1'b0});
    end
    clearn = 1'b0;
    cyc("final_clear", 3'b000);
    clearn = 1'b1;

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (vq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", vq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
